int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt controller that drives the CPU datapath's interrupt-request inputs ie1..ie4.
- The datapath responds to these inputs as follows: it priority-encodes them, selects a fixed vector and pushes the return PC onto the stack.
- This block sits between raw peripheral request lines and the datapath. It synchronises and edge-detects the lines, holds pending state and applies a mask.
- It issues exactly one single-cycle request at a time and blocks further requests until the CPU signals return-from-interrupt, which is the stack pop.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per request line (legal values 2..3).
- LEVEL_MODE, 0, 0 means rising-edge-triggered pending; 1 means level-sensitive (pending follows the synchronised line while unmasked).

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- irq_in  in  4  raw asynchronous request lines; bit 0 is highest priority.
- mask_we  in  1  one-cycle strobe that writes the mask register.
- mask_wdata  in  4  new mask value; bit=1 enables the corresponding line.
- reti  in  1  return-from-interrupt strobe, tied to the datapath pop.
- ie1, ie2, ie3, ie4  out  1 each  one-hot registered request pulses to the datapath.
- busy  out  1  high from the issue cycle until reti is accepted.
- status  out  8  {in_service_id[1:0], busy, 1'b0, pending[3:0]}; readable through a CPU input port.

Behaviour:
- Reset: pending=0, mask=0, sync chains=0, edge-history flops=0, state=IDLE, ie1..ie4=0, busy=0, in_service_id=0.
- Synchronisation: each irq_in bit passes through SYNC_STAGES flops. An edge is detected when the synchronised bit is 1 and its previous value was 0.
- Pending, edge mode:
  - A detected edge sets pending[i].
  - Issuing line i clears pending[i].
  - If a set and a clear hit the same line in the same cycle, the set wins and pending stays 1.
- Pending, level mode: pending[i] equals the synchronised bit. The issue does not clear it; the peripheral must drop the line.
- Mask:
  - When mask_we=1, mask takes mask_wdata at the next edge.
  - Masked lines still accumulate pending state; they are not issued.
  - Unmasking an already-pending line allows it to issue in the following IDLE cycle.
- FSM:
  - IDLE: if (pending & mask) != 0, select the lowest set index i, go to ISSUE, register ie(i+1)=1 and in_service_id=i.
  - ISSUE: lasts exactly one cycle with ie(i+1)=1, then goes to SERVICE. All ie outputs are 0 from then on.
  - SERVICE: busy=1; no new issues. When reti=1, go to IDLE; the next issue is possible at the earliest one cycle later.
  - reti in IDLE or ISSUE: ignored. reti in ISSUE is not latched.
- Latency: irq_in high and stable before edge 1 gives pending=1 after edge SYNC_STAGES+1 and ie high after edge SYNC_STAGES+2, for one cycle.
- ie outputs are always one-hot or all zero, and are never combinationally derived.
- busy=1 in ISSUE and SERVICE, 0 in IDLE.
- Simultaneous requests: the lowest index wins. The others remain pending and issue in order after successive reti strobes.
- Nesting: not supported. Requests arriving in SERVICE only set pending.
- Reset asserted mid-service: everything returns to reset values immediately and pending requests are lost.

Decomposition:
- Shared package constants:
  - FSM state encodings IDLE=2'd0, ISSUE=2'd1, SERVICE=2'd2.
  - NUM_IRQ=4.
  - Status bit positions.
- Sub-module irq_sync_edge, one per line, instantiated 4x:
  - Parameterised by SYNC_STAGES.
  - Outputs the synchronised level and a one-cycle rise pulse.
  - Async active-high reset.

Test Plan:
- Basic issue: reset, set mask=4'b0100, pulse irq_in[2] high, SYNC_STAGES=2 -> ie3=1 for exactly one cycle after edge 4, busy=1, status=8'b10_1_0_0000.
- Priority: with mask=4'b1111, raise irq_in[3] and irq_in[1] in the same cycle -> ie2 issues first and pending=4'b1000. After reti, ie4 issues 2 cycles later.
- Masking: mask=0, edge on irq_in[0] -> no ie and pending=4'b0001. Write mask=4'b0001 -> ie1 pulses 2 cycles after the mask write.
- Blocking: while busy, edge on irq_in[0] -> no ie output until reti. ie1 follows after reti. A reti issued in IDLE changes nothing.
- Set-wins: an edge on irq_in[1] is detected in the same cycle that line 1 issues -> pending[1] stays 1 and a second ie2 follows the next reti.
- Reset mid-service: assert reset during SERVICE with pending=4'b0110 -> busy=0, pending=0, all ie=0 immediately. No issues occur after release until new edges arrive.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: line count, FSM encoding,
// status-byte field positions and the priority-select helper.
package int_ctrl_pkg;

   localparam int NUM_IRQ = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      SERVICE = 2'd2
   } state_e;

   // status = {in_service_id[1:0], busy, 1'b0, pending[3:0]}
   localparam int ST_PEND_LSB = 0;
   localparam int ST_ZERO_BIT = 4;
   localparam int ST_BUSY_BIT = 5;
   localparam int ST_ID_LSB   = 6;

   // Lowest set index wins (bit 0 is highest priority).
   function automatic logic [1:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
      lowest_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (v[i]) lowest_idx = i[1:0];
   endfunction

endpackage

// File: rtl/int_ctrl_sync.sv
// One request line: SYNC_STAGES-deep synchroniser plus rising-edge detector.
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic irq_i,
   output logic level_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the raw line through the chain and remember the last synced level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises four request lines, tracks pending
// state under a mask and issues one registered ie pulse per service window,
// re-arming only after the CPU's return-from-interrupt strobe.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter bit LEVEL_MODE  = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   input  logic               reti,
   output logic               ie1,
   output logic               ie2,
   output logic               ie3,
   output logic               ie4,
   output logic               busy,
   output logic [7:0]         status
);

   logic [NUM_IRQ-1:0] level, rise;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] mask_q;
   logic [NUM_IRQ-1:0] ie_q;
   logic [NUM_IRQ-1:0] eligible, issue_clr;
   logic [1:0]         sel, id_q;
   logic               busy_q;
   state_e             state_q;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk     (clk),
         .reset   (reset),
         .irq_i   (irq_in[g]),
         .level_o (level[g]),
         .rise_o  (rise[g])
      );
   end

   assign eligible = pending_q & mask_q;
   assign sel      = lowest_idx(eligible);

   // Line being issued this cycle; used to clear its pending bit.
   always_comb begin
      issue_clr = '0;
      if (state_q == IDLE && |eligible)
         issue_clr = NUM_IRQ'(1) << sel;
   end

   // Edge mode: a new edge beats a same-cycle issue clear. Level mode: mirror the line.
   always_comb begin
      pending_d = (pending_q & ~issue_clr) | rise;
      if (LEVEL_MODE)
         pending_d = level;
   end

   // Pending and mask registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
         mask_q    <= '0;
      end else begin
         pending_q <= pending_d;
         if (mask_we) mask_q <= mask_wdata;
      end
   end

   // Issue FSM with registered ie, busy and in-service id.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ie_q    <= '0;
         busy_q  <= 1'b0;
         id_q    <= '0;
      end else begin
         ie_q <= '0;
         case (state_q)
            IDLE: begin
               if (|eligible) begin
                  state_q <= ISSUE;
                  ie_q    <= NUM_IRQ'(1) << sel;
                  id_q    <= sel;
                  busy_q  <= 1'b1;
               end
            end
            ISSUE: state_q <= SERVICE;
            SERVICE: begin
               if (reti) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign {ie4, ie3, ie2, ie1} = ie_q;
   assign busy                 = busy_q;

   // Pack the CPU-visible status byte.
   always_comb begin
      status                                  = '0;
      status[ST_PEND_LSB +: NUM_IRQ]          = pending_q;
      status[ST_ZERO_BIT]                     = 1'b0;
      status[ST_BUSY_BIT]                     = busy_q;
      status[ST_ID_LSB +: 2]                  = id_q;
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl (SYNC_STAGES=2, edge mode). Expected ie line
// ids are queued as stimulus is driven and popped when an ie pulse appears.
module tb_int_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq_in;
   logic       mask_we;
   logic [3:0] mask_wdata;
   logic       reti;
   logic       ie1, ie2, ie3, ie4;
   logic       busy;
   logic [7:0] status;
   logic [3:0] ie;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   assign ie = {ie4, ie3, ie2, ie1};

   int_ctrl #(.SYNC_STAGES(2), .LEVEL_MODE(1'b0)) dut (
      .clk        (clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .reti       (reti),
      .ie1        (ie1),
      .ie2        (ie2),
      .ie3        (ie3),
      .ie4        (ie4),
      .busy       (busy),
      .status     (status)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_mask(input logic [3:0] m);
      mask_we = 1'b1; mask_wdata = m;
      step(1);
      mask_we = 1'b0;
   endtask

   task automatic do_reti();
      reti = 1'b1;
      step(1);
      reti = 1'b0;
   endtask

   // Scoreboard: every ie pulse must match the next queued line id.
   always @(negedge clk) begin
      if (ie !== 4'b0000) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL ie_unexpected observed=%b expected=none", ie);
         end else begin
            automatic int id = exp_q.pop_front();
            automatic logic [3:0] want = 4'b0001 << id;
            assert (ie === want) else begin
               errors++;
               $error("FAIL ie_pulse observed=%b expected=%b", ie, want);
            end
         end
      end
   end

   initial begin
      logic [7:0] st_before;
      reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; reti = 1'b0;
      step(2);
      chk("reset_status", status, 8'h00);
      chk("reset_ie", {4'b0, ie}, 8'h00);
      chk("reset_busy", {7'b0, busy}, 8'h00);
      reset = 1'b0;
      step(1);

      // Basic issue on line 2.
      write_mask(4'b0100);
      exp_q.push_back(2);
      irq_in[2] = 1'b1;
      step(3);
      chk("basic_pending", {4'b0, status[3:0]}, 8'h04);
      chk("basic_no_ie_yet", {4'b0, ie}, 8'h00);
      step(1);
      chk("basic_ie3", {4'b0, ie}, 8'h04);
      chk("basic_status", status, 8'b10_1_0_0000);
      irq_in[2] = 1'b0;
      step(1);
      chk("basic_ie_single", {4'b0, ie}, 8'h00);
      chk("basic_busy_service", {7'b0, busy}, 8'h01);
      do_reti();
      chk("basic_busy_clear", {7'b0, busy}, 8'h00);
      step(3);

      // Priority: lines 1 and 3 together.
      write_mask(4'b1111);
      exp_q.push_back(1);
      exp_q.push_back(3);
      irq_in = 4'b1010;
      step(4);
      chk("prio_ie2", {4'b0, ie}, 8'h02);
      chk("prio_pending", {4'b0, status[3:0]}, 8'h08);
      irq_in = '0;
      step(3);
      chk("prio_hold", {4'b0, ie}, 8'h00);
      do_reti();
      chk("prio_idle", {7'b0, busy}, 8'h00);
      step(1);
      chk("prio_ie4", {4'b0, ie}, 8'h08);
      chk("prio_id", {6'b0, status[7:6]}, 8'h03);
      step(1);
      do_reti();
      step(2);

      // Masking: edge on line 0 while masked.
      write_mask(4'b0000);
      irq_in[0] = 1'b1;
      step(3);
      irq_in[0] = 1'b0;
      step(3);
      chk("mask_pending", {4'b0, status[3:0]}, 8'h01);
      chk("mask_no_issue", {7'b0, busy}, 8'h00);
      exp_q.push_back(0);
      write_mask(4'b0001);
      chk("mask_no_ie_at_write", {4'b0, ie}, 8'h00);
      step(1);
      chk("mask_ie1", {4'b0, ie}, 8'h01);
      step(1);
      do_reti();
      step(2);

      // Blocking: new request during service waits for reti.
      write_mask(4'b0011);
      exp_q.push_back(1);
      irq_in[1] = 1'b1;
      step(4);
      chk("block_ie2", {4'b0, ie}, 8'h02);
      irq_in[1] = 1'b0;
      step(1);
      irq_in[0] = 1'b1;
      step(4);
      irq_in[0] = 1'b0;
      chk("block_no_ie", {4'b0, ie}, 8'h00);
      chk("block_pending", {4'b0, status[3:0]}, 8'h01);
      chk("block_busy", {7'b0, busy}, 8'h01);
      exp_q.push_back(0);
      do_reti();
      chk("block_idle_gap", {4'b0, ie}, 8'h00);
      step(1);
      chk("block_ie1", {4'b0, ie}, 8'h01);
      step(1);
      do_reti();
      step(2);
      st_before = status;
      do_reti();
      step(2);
      chk("reti_idle_status", status, st_before);
      chk("reti_idle_busy", {7'b0, busy}, 8'h00);

      // Set-wins: second edge on line 1 lands in its issue cycle.
      write_mask(4'b0000);
      irq_in[1] = 1'b1;
      step(3);
      irq_in[1] = 1'b0;
      step(4);
      chk("setwin_pre_pending", {4'b0, status[3:0]}, 8'h02);
      irq_in[1] = 1'b1;
      step(1);
      mask_we = 1'b1; mask_wdata = 4'b0010;
      exp_q.push_back(1);
      exp_q.push_back(1);
      step(1);
      mask_we = 1'b0;
      step(1);
      chk("setwin_ie2", {4'b0, ie}, 8'h02);
      chk("setwin_pending_kept", {4'b0, status[3:0]}, 8'h02);
      irq_in[1] = 1'b0;
      step(2);
      do_reti();
      step(1);
      chk("setwin_second_ie2", {4'b0, ie}, 8'h02);
      chk("setwin_pending_clear", {4'b0, status[3:0]}, 8'h00);
      step(1);
      do_reti();
      step(2);

      // Reset mid-service with lines 1,2 still pending.
      write_mask(4'b1111);
      exp_q.push_back(0);
      irq_in = 4'b0111;
      step(4);
      chk("rst_ie1", {4'b0, ie}, 8'h01);
      irq_in = '0;
      step(1);
      chk("rst_pre_status", status, 8'b00_1_0_0110);
      reset = 1'b1;
      #1;
      chk("rst_busy", {7'b0, busy}, 8'h00);
      chk("rst_status", status, 8'h00);
      chk("rst_ie", {4'b0, ie}, 8'h00);
      step(2);
      reset = 1'b0;
      step(10);
      chk("rst_quiet_busy", {7'b0, busy}, 8'h00);
      chk("rst_quiet_status", status, 8'h00);

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL ie_missing observed=%0d_outstanding expected=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
